// File: rtl/sequence_game_pkg.sv
// Shared types and helpers for the sequence game engine: state encodings,
// LFSR feedback mask and width helpers.
package sequence_game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GEN      = 4'd1,
    ST_PLAY_ON  = 4'd2,
    ST_PLAY_GAP = 4'd3,
    ST_WAIT     = 4'd4,
    ST_CHECK    = 4'd5,
    ST_WON      = 4'd6,
    ST_LOST     = 4'd7
  } game_state_t;

  // Right-shifting Galois mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int level_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sequence_game_core_if.sv
// Board-side bundle of the game engine: start/keys in, LEDs and status out.
interface sequence_game_core_if
  import sequence_game_pkg::*;
#(
  parameter int NUM_NOTES = 4,
  parameter int MAX_LEN   = 16
);
  localparam int LVLW = level_width(MAX_LEN);

  logic                 start;
  logic [NUM_NOTES-1:0] note_inputs;
  logic [NUM_NOTES-1:0] note_outputs;
  logic [3:0]           state;
  logic [LVLW-1:0]      level;
  logic                 won;
  logic                 lost;

  modport master (
    output start, note_inputs,
    input  note_outputs, state, level, won, lost
  );

  modport slave (
    input  start, note_inputs,
    output note_outputs, state, level, won, lost
  );
endinterface

// File: rtl/note_lfsr.sv
// Free-running 16-bit Galois LFSR folded down to a note index in 0..NUM_NOTES-1.
module note_lfsr
  import sequence_game_pkg::*;
#(
  parameter int          NUM_NOTES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDXW      = idx_width(NUM_NOTES)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [IDXW-1:0] note
);
  logic [15:0]     lfsr_reg;
  logic [15:0]     lfsr_next;
  logic [IDXW-1:0] raw_idx;

  always_comb begin
    lfsr_next = lfsr_reg >> 1;
    if (lfsr_reg[0]) lfsr_next = lfsr_next ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= lfsr_next;
  end

  assign raw_idx = lfsr_reg[IDXW-1:0];

  // Raw index is below 2*NUM_NOTES, so one conditional subtract is enough
  generate
    if (NUM_NOTES == (1 << IDXW)) begin : g_pow2
      assign note = raw_idx;
    end else begin : g_fold
      assign note = ({1'b0, raw_idx} >= (IDXW+1)'(NUM_NOTES))
                  ? IDXW'({1'b0, raw_idx} - (IDXW+1)'(NUM_NOTES))
                  : raw_idx;
    end
  endgenerate
endmodule

// File: rtl/sequence_game_core.sv
// Simon-style engine: grow sequence, play it back, check presses one by one.
// Define SEQUENCE_GAME_TIMEOUT_EN to lose after TIMEOUT idle cycles in WAIT.
module sequence_game_core
  import sequence_game_pkg::*;
#(
  parameter int          NUM_NOTES   = 4,
  parameter int          MAX_LEN     = 16,
  parameter int unsigned NOTE_PERIOD = 25000000,
  parameter int unsigned GAP_PERIOD  = 12500000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned TIMEOUT     = 250000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_game_core_if.slave  bus
);
  localparam int IDXW = idx_width(NUM_NOTES);
  localparam int LVLW = level_width(MAX_LEN);
  localparam int AW   = idx_width(MAX_LEN);

  game_state_t          state_reg, state_next;
  logic [LVLW-1:0]      level_reg, level_next;
  logic [LVLW-1:0]      idx_reg, idx_next, idx_plus_one;
  logic [31:0]          timer_reg, timer_next;
  logic [NUM_NOTES-1:0] prev_keys_reg, rise_reg, rise_next, rise_now;
  logic [NUM_NOTES-1:0] cur_onehot;
  logic [IDXW-1:0]      new_note;
  logic                 seq_we;
  logic [IDXW-1:0]      seq_mem [MAX_LEN];

  note_lfsr #(
    .NUM_NOTES (NUM_NOTES),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .note  (new_note)
  );

  always_ff @(posedge clk) begin
    if (seq_we) seq_mem[level_reg[AW-1:0]] <= new_note;
  end

  assign idx_plus_one = idx_reg + LVLW'(1);
  assign cur_onehot   = NUM_NOTES'(1) << seq_mem[idx_reg[AW-1:0]];
  // prev_keys tracks every cycle, so keys already down on WAIT entry never rise
  assign rise_now     = bus.note_inputs & ~prev_keys_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      level_reg     <= '0;
      idx_reg       <= '0;
      timer_reg     <= '0;
      prev_keys_reg <= '0;
      rise_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      idx_reg       <= idx_next;
      timer_reg     <= timer_next;
      prev_keys_reg <= bus.note_inputs;
      rise_reg      <= rise_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    idx_next   = idx_reg;
    rise_next  = rise_reg;
    seq_we     = 1'b0;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_GEN;
      ST_GEN: begin
        seq_we     = 1'b1;
        level_next = level_reg + LVLW'(1);
        idx_next   = '0;
        state_next = ST_PLAY_ON;
      end
      ST_PLAY_ON: if (timer_reg == NOTE_PERIOD - 1) state_next = ST_PLAY_GAP;
      ST_PLAY_GAP: begin
        if (timer_reg == GAP_PERIOD - 1) begin
          if (idx_plus_one < level_reg) begin
            idx_next   = idx_plus_one;
            state_next = ST_PLAY_ON;
          end else begin
            idx_next   = '0;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (rise_now != '0) begin
          rise_next  = rise_now;
          state_next = ST_CHECK;
        end
`ifdef SEQUENCE_GAME_TIMEOUT_EN
        else if (timer_reg == TIMEOUT - 1) begin
          state_next = ST_LOST;
        end
`endif
      end
      ST_CHECK: begin
        // Exact match against a one-hot also rejects multi-key rises
        if (rise_reg != cur_onehot) begin
          state_next = ST_LOST;
        end else if (idx_plus_one == level_reg) begin
          state_next = (level_reg == LVLW'(MAX_LEN)) ? ST_WON : ST_GEN;
        end else begin
          idx_next   = idx_plus_one;
          state_next = ST_WAIT;
        end
      end
      ST_WON, ST_LOST: begin
        if (bus.start) begin
          level_next = '0;
          state_next = ST_GEN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    timer_next = (state_next != state_reg) ? '0 : timer_reg + 32'd1;
  end

  always_comb begin
    bus.note_outputs = '0;
    case (state_reg)
      ST_PLAY_ON: bus.note_outputs = cur_onehot;
      ST_WAIT:    bus.note_outputs = bus.note_inputs;
      ST_WON:     bus.note_outputs = '1;
      default:    bus.note_outputs = '0;
    endcase
  end

  assign bus.state = state_reg;
  assign bus.level = level_reg;
  assign bus.won   = (state_reg == ST_WON);
  assign bus.lost  = (state_reg == ST_LOST);
endmodule

// File: tb/tb_sequence_game_core.sv
// Scenario bench for sequence_game_core: small parameters, model LFSR, playback scoreboard.
module tb_sequence_game_core;
  localparam int          NN     = 4;
  localparam int          ML     = 3;
  localparam int          NOTE_P = 4;
  localparam int          GAP_P  = 2;
  localparam int          TO     = 20;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sequence_game_core_if #(.NUM_NOTES(NN), .MAX_LEN(ML)) bus ();

  sequence_game_core #(
    .NUM_NOTES   (NN),
    .MAX_LEN     (ML),
    .NOTE_PERIOD (NOTE_P),
    .GAP_PERIOD  (GAP_P),
    .LFSR_SEED   (SEED),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_lfsr;
  int          game_seq [ML];
  int          exp_q [$];
  int          first_note;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    logic [15:0] n;
    n = {1'b0, r[15:1]};
    if (r[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_lfsr <= SEED;
    else       model_lfsr <= lfsr_step(model_lfsr);
  end

  function automatic int model_note();
    int n;
    n = int'(model_lfsr & 16'h0003);
    if (n >= NN) n = n - NN;
    return n;
  endfunction

  function automatic logic [3:0] oh(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return one << n;
  endfunction

  task automatic wait_state(input logic [3:0] s, input string nm);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.state === s) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: state=%0d expected %0d within 50 cycles", nm, bus.state, s);
    end
  endtask

  // Records the newly generated note from the model, then checks full playback
  task automatic play_round(input int len, input bit hold);
    logic [3:0] held;
    int e;
    game_seq[len-1] = model_note();
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(game_seq[i]);
    held = hold ? oh(game_seq[0]) : 4'b0000;
    for (int n = 0; n < len; n++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < NOTE_P; c++) begin
        @(negedge clk);
        total++;
        if (bus.state !== 4'd2 || bus.note_outputs !== oh(e)) begin
          bad++;
          $display("FAIL play_on: len=%0d n=%0d cyc=%0d state=%0d leds=%b expected state=2 leds=%b",
                   len, n, c, bus.state, bus.note_outputs, oh(e));
        end
      end
      if (n == 0) begin
        total++;
        if (bus.level !== 2'(len)) begin
          bad++;
          $display("FAIL level: got %0d expected %0d", bus.level, len);
        end
      end
      for (int c = 0; c < GAP_P; c++) begin
        @(negedge clk);
        total++;
        if (bus.state !== 4'd3 || bus.note_outputs !== 4'b0000) begin
          bad++;
          $display("FAIL play_gap: len=%0d n=%0d cyc=%0d state=%0d leds=%b expected state=3 leds=0000",
                   len, n, c, bus.state, bus.note_outputs);
        end
        if (hold && n == len - 1 && c == 0) bus.note_inputs = held;
      end
    end
    @(negedge clk);
    total++;
    if (bus.state !== 4'd4 || bus.note_outputs !== held) begin
      bad++;
      $display("FAIL wait_entry: state=%0d leds=%b expected state=4 leds=%b",
               bus.state, bus.note_outputs, held);
    end
    $display("round len=%0d played, newest note=%0d", len, game_seq[len-1]);
  endtask

  task automatic press(input logic [3:0] keys, input logic [3:0] exp_s, input string nm);
    bus.note_inputs = keys;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd5) begin
      bad++;
      $display("FAIL %s_check: state=%0d expected 5", nm, bus.state);
    end
    bus.note_inputs = 4'b0000;
    @(negedge clk);
    total++;
    if (bus.state !== exp_s) begin
      bad++;
      $display("FAIL %s_next: state=%0d expected %0d", nm, bus.state, exp_s);
    end
    $display("press %s keys=%b -> state=%0d", nm, keys, bus.state);
  endtask

  task automatic begin_game(input string nm);
    bus.start = 1'b1;
    wait_state(4'd1, nm);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.state !== 4'd0 || bus.level !== 2'd0 || bus.note_outputs !== 4'b0000 ||
        bus.won !== 1'b0 || bus.lost !== 1'b0) begin
      bad++;
      $display("FAIL reset: state=%0d level=%0d leds=%b won=%b lost=%b expected all zero",
               bus.state, bus.level, bus.note_outputs, bus.won, bus.lost);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.level !== 2'd0) begin
      bad++;
      $display("FAIL reset_release: state=%0d level=%0d expected 0 0", bus.state, bus.level);
    end
  endtask

  task automatic test_full_game();
    @(negedge clk);
    begin_game("gen_first");
    first_note = model_note();
    play_round(1, 1'b0);
    press(oh(game_seq[0]), 4'd1, "r1k0");
    play_round(2, 1'b0);
    press(oh(game_seq[0]), 4'd4, "r2k0");
    press(oh(game_seq[1]), 4'd1, "r2k1");
    play_round(3, 1'b0);
    press(oh(game_seq[0]), 4'd4, "r3k0");
    press(oh(game_seq[1]), 4'd4, "r3k1");
    press(oh(game_seq[2]), 4'd6, "r3k2");
    total++;
    if (bus.won !== 1'b1 || bus.lost !== 1'b0 || bus.note_outputs !== 4'b1111 || bus.level !== 2'd3) begin
      bad++;
      $display("FAIL won: won=%b lost=%b leds=%b level=%0d expected 1 0 1111 3",
               bus.won, bus.lost, bus.note_outputs, bus.level);
    end
  endtask

  task automatic test_wrong_key();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.state !== 4'd1 || bus.level !== 2'd0) begin
      bad++;
      $display("FAIL restart_gen: state=%0d level=%0d expected 1 0", bus.state, bus.level);
    end
    play_round(1, 1'b0);
    press(oh(game_seq[0]), 4'd1, "w1k0");
    play_round(2, 1'b0);
    press(oh((game_seq[0] + 1) % NN), 4'd7, "wrong");
    total++;
    if (bus.lost !== 1'b1 || bus.won !== 1'b0 || bus.note_outputs !== 4'b0000 || bus.level !== 2'd2) begin
      bad++;
      $display("FAIL lost: lost=%b won=%b leds=%b level=%0d expected 1 0 0000 2",
               bus.lost, bus.won, bus.note_outputs, bus.level);
    end
  endtask

  task automatic test_double_key();
    begin_game("gen_double");
    play_round(1, 1'b0);
    press(4'b0101, 4'd7, "double");
    total++;
    if (bus.lost !== 1'b1) begin
      bad++;
      $display("FAIL double_lost: lost=%b expected 1", bus.lost);
    end
  endtask

  task automatic test_held_key();
    begin_game("gen_held");
    play_round(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.state !== 4'd4) begin
        bad++;
        $display("FAIL held_ignored: cyc=%0d state=%0d expected 4", k, bus.state);
      end
    end
    bus.note_inputs = 4'b0000;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd4) begin
      bad++;
      $display("FAIL release_ignored: state=%0d expected 4", bus.state);
    end
    press(oh(game_seq[0]), 4'd1, "repress");
  endtask

  task automatic test_reset_midplay();
    @(negedge clk);
    @(negedge clk);
    #2;
    total++;
    if (bus.state !== 4'd2) begin
      bad++;
      $display("FAIL pre_reset: state=%0d expected 2", bus.state);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.level !== 2'd0 || bus.note_outputs !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: state=%0d level=%0d leds=%b expected 0 0 0000",
               bus.state, bus.level, bus.note_outputs);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    begin_game("gen_after_reset");
    @(negedge clk);
    total++;
    if (bus.state !== 4'd2 || bus.note_outputs !== oh(first_note)) begin
      bad++;
      $display("FAIL seed_repeat: state=%0d leds=%b expected 2 %b",
               bus.state, bus.note_outputs, oh(first_note));
    end
    wait_state(4'd4, "wait_after_reset");
  endtask

  task automatic test_timeout();
`ifdef SEQUENCE_GAME_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge clk);
      total++;
      if (bus.state !== 4'd4) begin
        bad++;
        $display("FAIL timeout_early: cyc=%0d state=%0d expected 4", k, bus.state);
      end
    end
    @(negedge clk);
    total++;
    if (bus.state !== 4'd7 || bus.lost !== 1'b1) begin
      bad++;
      $display("FAIL timeout: state=%0d lost=%b expected 7 1", bus.state, bus.lost);
    end
`else
    repeat (100) @(negedge clk);
    total++;
    if (bus.state !== 4'd4) begin
      bad++;
      $display("FAIL no_timeout: state=%0d expected 4", bus.state);
    end
`endif
    $display("idle wait finished in state=%0d", bus.state);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.note_inputs = 4'b0000;
    test_reset();
    test_full_game();
    test_wrong_key();
    test_double_key();
    test_held_key();
    test_reset_midplay();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
